// File: rtl/alu_mc.sv
// Multi-cycle ALU: RV32I base ops with latency 1, valid/ready handshake and a registered result.
// Defining ALU_MEXT_EN adds iterative RV32M multiply/divide (WIDTH iterations, latency WIDTH+1).
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_state_n;
  logic             w_accept, w_load, w_err_n;
  logic [WIDTH-1:0] w_res, w_base;
  logic [WIDTH-1:0] r_y;
  logic             r_z, r_err;

  function automatic logic [WIDTH-1:0] base_op(input logic [3:0] f, input logic [WIDTH-1:0] ia,
                                               input logic [WIDTH-1:0] ib);
    logic [SHW-1:0] sh;
    sh = ib[SHW-1:0];
    casez (f)
      4'b0000: base_op = ia + ib;
      4'b0001: base_op = ia - ib;
      4'b001?: base_op = ia << sh;
      4'b010?: base_op = {{(WIDTH-1){1'b0}}, ($signed(ia) < $signed(ib))};
      4'b011?: base_op = {{(WIDTH-1){1'b0}}, (ia < ib)};
      4'b100?: base_op = ia ^ ib;
      4'b1010: base_op = ia >> sh;
      4'b1011: base_op = $unsigned($signed(ia) >>> sh);
      4'b110?: base_op = ia | ib;
      default: base_op = ia & ib;
    endcase
  endfunction

  assign w_base   = base_op(op[3:0], a, b);
  assign w_accept = in_valid && (r_state == S_IDLE);

`ifdef ALU_MEXT_EN
  logic signed [WIDTH-1:0] w_a_s, w_b_s;
  logic [WIDTH-1:0]   r_hi, r_lo, r_m, r_a;
  logic [2:0]         r_f;
  logic               r_neg, r_rneg, r_bzero;
  logic [SHW-1:0]     r_cnt;
  logic               w_last, w_asgn, w_bsgn;
  logic [WIDTH-1:0]   w_amag, w_bmag, w_hi_n, w_lo_n, w_q, w_r, w_mres;
  logic [WIDTH:0]     w_sum, w_shl, w_diff;
  logic [2*WIDTH-1:0] w_prod;

  function automatic logic [WIDTH-1:0] neg_w(input logic n, input logic [WIDTH-1:0] v);
    neg_w = n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic n, input logic [2*WIDTH-1:0] v);
    neg_2w = n ? (~v + 1'b1) : v;
  endfunction

  // Operand signedness: mulh/mulhsu/div/rem treat a as signed; mulh/div/rem treat b as signed.
  assign w_a_s  = a;
  assign w_b_s  = b;
  assign w_asgn = w_a_s[WIDTH-1] & (op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10));
  assign w_bsgn = w_b_s[WIDTH-1] & (op[2] ? ~op[0] : (op[1:0] == 2'b01));
  assign w_amag = neg_w(w_asgn, a);
  assign w_bmag = neg_w(w_bsgn, b);
  assign w_last = (r_state == S_BUSY) && (r_cnt == SHW'(WIDTH-1));

  always_comb begin
    w_sum  = '0;
    w_shl  = '0;
    w_diff = '0;
    if (!r_f[2]) begin
      // Shift-add: {hi,lo} shifts right, multiplier bits consumed from lo[0]
      w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_shl  = {r_hi, r_lo[WIDTH-1]};
      w_diff = w_shl - {1'b0, r_m};
      if (!w_diff[WIDTH]) begin
        w_hi_n = w_diff[WIDTH-1:0];
        w_lo_n = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_n = w_shl[WIDTH-1:0];
        w_lo_n = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign w_prod = neg_2w(r_neg, {w_hi_n, w_lo_n});
  assign w_q    = r_bzero ? '1  : neg_w(r_neg, w_lo_n);
  assign w_r    = r_bzero ? r_a : neg_w(r_rneg, w_hi_n);
  assign w_mres = r_f[2] ? (r_f[1] ? w_r : w_q)
                         : ((r_f[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= '0;
    else if (w_accept)           r_cnt <= '0;
    else if (r_state == S_BUSY)  r_cnt <= r_cnt + SHW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_accept && op[4]) begin
      r_f     <= op[2:0];
      r_a     <= a;
      r_m     <= w_bmag;
      r_lo    <= w_amag;
      r_hi    <= '0;
      r_neg   <= w_asgn ^ w_bsgn;
      r_rneg  <= w_asgn;
      r_bzero <= (b == '0);
    end else if (r_state == S_BUSY) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_res     = w_base;
    w_err_n   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!op[4]) begin
            w_load    = 1'b1;
            w_state_n = S_DONE;
          end else begin
`ifdef ALU_MEXT_EN
            w_state_n = S_BUSY;
`else
            w_load    = 1'b1;
            w_res     = '0;
            w_err_n   = 1'b1;
            w_state_n = S_DONE;
`endif
          end
        end
      end
      S_BUSY: begin
`ifdef ALU_MEXT_EN
        if (w_last) begin
          w_load    = 1'b1;
          w_res     = w_mres;
          w_state_n = S_DONE;
        end
`else
        w_state_n = S_IDLE;
`endif
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y   <= '0;
      r_z   <= 1'b1;
      r_err <= 1'b0;
    end else if (w_load) begin
      r_y   <= w_res;
      r_z   <= (w_res == '0);
      r_err <= w_err_n;
    end
  end

  assign y   = r_y;
  assign z   = r_z;
  assign err = r_err;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed vectors, expected results queued at issue and checked by a monitor.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, z, err;
  logic [W-1:0] y;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .z(z), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] y;
    logic         z;
    logic         err;
    int           lat;
    int           acc;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  bit   got_first = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  // Monitor: latency on the first cycle a result is shown, y/z/err on handoff
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: out_valid=1 with nothing outstanding, y=%h", y);
      end else begin
        if (!got_first) begin
          got_first = 1'b1;
          chk({sbq[0].name, "_lat"}, W'(cyc - sbq[0].acc + 1), W'(sbq[0].lat));
        end
        if (out_ready) begin
          e = sbq.pop_front();
          got_first = 1'b0;
          chk({e.name, "_y"}, y, e.y);
          chk({e.name, "_z"}, W'(z), W'(e.z));
          chk({e.name, "_err"}, W'(err), W'(e.err));
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [4:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] ey, input logic ez, input logic ee, input int el);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout: in_ready=%b want 1", nm, in_ready);
      return;
    end
    in_valid = 1'b1;
    op = o;
    a = ia;
    b = ib;
    @(posedge clk); #1;
    e.y = ey; e.z = ez; e.err = ee; e.lat = el; e.acc = cyc; e.name = nm;
    sbq.push_back(e);
    in_valid = 1'b0;
    op = 5'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: outstanding=%0d want 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcnt;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_y", y, '0);
    chk("rst_z", W'(z), W'(1));
    chk("rst_err", W'(err), W'(0));

    issue("add",  5'b00000, 1, 5, 32'h6, 0, 0, 1);
    issue("sub",  5'b00001, 1, 5, 32'hFFFFFFFC, 0, 0, 1);
    issue("sll",  5'b00010, 1, 5, 32'h20, 0, 0, 1);
    issue("sllm", 5'b00011, 1, 32'h25, 32'h20, 0, 0, 1);
    issue("slt",  5'b00100, 1, 5, 32'h1, 0, 0, 1);
    issue("sltn", 5'b00100, 32'hFFFFFFFF, 1, 32'h1, 0, 0, 1);
    issue("sltu", 5'b00110, 1, 5, 32'h1, 0, 0, 1);
    issue("sltun", 5'b00110, 32'hFFFFFFFF, 1, 32'h0, 1, 0, 1);
    issue("xor",  5'b01000, 1, 5, 32'h4, 0, 0, 1);
    issue("or",   5'b01100, 1, 5, 32'h5, 0, 0, 1);
    issue("and",  5'b01110, 1, 5, 32'h1, 0, 0, 1);
    issue("subz", 5'b00001, 5, 5, 32'h0, 1, 0, 1);
    issue("srl",  5'b01010, 32'h80000000, 4, 32'h08000000, 0, 0, 1);
    issue("sra",  5'b01011, 32'h80000000, 4, 32'hF8000000, 0, 0, 1);
    drain();

    out_ready = 1'b0;
    issue("bp_add", 5'b00000, 10, 20, 32'd30, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_y_held", y, 32'd30);
      chk("bp_in_ready", W'(in_ready), W'(0));
      in_valid = 1'b1;
      op = 5'b00001;
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

`ifdef ALU_MEXT_EN
    issue("mul",    5'b10000, 7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0, W+1);
    issue("mulh",   5'b10001, 32'hFFFFFFFE, 3, 32'hFFFFFFFF, 0, 0, W+1);
    issue("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, W+1);
    issue("mulhu",  5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, W+1);
    issue("div",    5'b10100, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 0, 0, W+1);
    issue("rem",    5'b10110, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 0, 0, W+1);
    issue("divnb",  5'b10100, 7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, W+1);
    issue("remnb",  5'b10110, 7, 32'hFFFFFFFE, 32'h1, 0, 0, W+1);
    issue("divu",   5'b10101, 100, 7, 32'd14, 0, 0, W+1);
    issue("remu",   5'b10111, 100, 7, 32'd2, 0, 0, W+1);
    issue("divu0",  5'b10101, 9, 0, 32'hFFFFFFFF, 0, 0, W+1);
    issue("remu0",  5'b10111, 9, 0, 32'd9, 0, 0, W+1);
    issue("div0",   5'b10100, 32'hFFFFFFFB, 0, 32'hFFFFFFFF, 0, 0, W+1);
    issue("rem0",   5'b10110, 32'hFFFFFFFB, 0, 32'hFFFFFFFB, 0, 0, W+1);
    issue("divov",  5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, W+1);
    issue("remov",  5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0, W+1);
    drain();

    in_valid = 1'b1;
    op = 5'b10000;
    a = 3;
    b = 4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_in_ready", W'(in_ready), W'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy_in_ready", W'(in_ready), W'(1));
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) vcnt++;
    end
    chk("rst_busy_no_out", W'(vcnt), W'(0));
    issue("post_rst_add", 5'b00000, 2, 3, 32'd5, 0, 0, 1);
`else
    issue("illegal_m", 5'b10100, 3, 4, 32'h0, 1, 1, 1);
    issue("after_ill", 5'b00000, 2, 3, 32'd5, 0, 0, 1);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
